mult_unit: RTL and testbench
============================

MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 The block SHALL have one parameter: DATA_W, default 8, operand and result width in bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; ports SHALL be as follows (clock and reset first):
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 START  input  1  request from control unit on a decoded MUL instruction; sampled only in IDLE.
REQ-006 OPERAND1  input  DATA_W  multiplicand, taken from register-file OUT1.
REQ-007 OPERAND2  input  DATA_W  multiplier, taken from register-file OUT2.
REQ-008 RESULT  output  DATA_W  low DATA_W bits of the unsigned product; drives the register-file IN mux.
REQ-009 BUSY  output  1  stall request to PC/pipeline while a multiply is in progress.
REQ-010 DONE  output  1  one-cycle pulse; result valid, used as register-file WRITE qualifier.
REQ-011 OVERFLOW  output  1  high when the upper DATA_W bits of the full product are non-zero.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN, DONE_ST.
REQ-013 IDLE -> RUN: at a rising edge with START=1, OPERAND1 and OPERAND2 are captured into internal registers, the 2*DATA_W accumulator is cleared, and the iteration counter is set to 0.
REQ-014 IDLE with START=0: remain in IDLE and hold all outputs.
REQ-015 RUN: each rising edge performs one shift-add step, LSB first. If the current multiplier bit is 1, add the shifted multiplicand to the accumulator. Then shift the multiplicand left by 1 and the multiplier right by 1, and increment the counter.
REQ-016 RUN -> DONE_ST: at the edge that performs iteration DATA_W (counter reaches DATA_W). Latency is fixed at DATA_W edges after the capture edge, regardless of operand values, including zero operands.
REQ-017 On entering DONE_ST, RESULT SHALL load product[DATA_W-1:0] and OVERFLOW SHALL load |product[2*DATA_W-1:DATA_W].
REQ-018 DONE_ST -> IDLE: unconditionally at the next rising edge, so DONE is high for exactly one cycle.
REQ-019 BUSY SHALL be 1 only in RUN, and 0 in IDLE and DONE_ST.
REQ-020 DONE SHALL be 1 only in DONE_ST.
REQ-021 START SHALL be ignored in RUN and DONE_ST. Continuous START gives back-to-back operations with one IDLE cycle between DONE and the next capture.
REQ-022 Changes on OPERAND1/OPERAND2 after the capture edge SHALL NOT affect the in-flight product.
REQ-023 RESULT and OVERFLOW SHALL hold their last value from DONE_ST until the next DONE_ST or reset.
REQ-024 Arithmetic SHALL be unsigned. The low DATA_W bits are identical for two's-complement operands; OVERFLOW is defined for unsigned interpretation only.
REQ-025 Accumulator additions SHALL be 2*DATA_W wide with no carry loss; the product never exceeds (2^DATA_W-1)^2.

Reset
REQ-026 RESET=1 SHALL immediately, without waiting for CLK, force state=IDLE, RESULT=0, OVERFLOW=0, BUSY=0, DONE=0, counter=0, accumulator=0 and operand registers=0.
REQ-027 Reset mid-operation SHALL discard the in-flight multiply; no DONE pulse is produced for it.
REQ-028 While RESET=1, START SHALL be ignored. The first capture can occur at the first rising edge after RESET deasserts.

Verification
REQ-029 Assert RESET asynchronously between clock edges -> RESULT=0x00, BUSY=0, DONE=0, OVERFLOW=0 immediately.
REQ-030 START with OPERAND1=0x05, OPERAND2=0x03 -> BUSY=1 for 8 cycles, then DONE=1 for exactly 1 cycle with RESULT=0x0F and OVERFLOW=0; then IDLE.
REQ-031 Boundary products: 0x10*0x10 -> RESULT=0x00, OVERFLOW=1; 0xFF*0xFF -> RESULT=0x01, OVERFLOW=1; 0x00*0xFF -> RESULT=0x00, OVERFLOW=0, still 8 BUSY cycles.
REQ-032 Start 0x0C*0x0A, then during RUN change operands to 0x01/0x01 and pulse START -> RESULT=0x78, exactly one DONE pulse, no second operation.
REQ-033 Start 0x09*0x09, assert RESET on the 4th RUN cycle, release, then start 0x07*0x06 -> no DONE for the first operation; second gives RESULT=0x2A after 8 BUSY cycles.
REQ-034 Hold START=1 with 0x02*0x03 -> repeated DONE pulses every 10 cycles (capture, 8 RUN, DONE_ST, IDLE), each with RESULT=0x06.

Source files
------------

// File: rtl/mult_unit.sv
// ---------------------------------------------------------------------------
// mult_unit
// Sequential shift-add unsigned multiplier for the datapath MUL instruction.
// One multiplier bit is consumed per clock (LSB first), so the latency is
// fixed at DATA_W RUN cycles whatever the operand values are.
//
// Ports
//   CLK       in   1       system clock, rising-edge active
//   RESET     in   1       asynchronous active-high reset
//   START     in   1       request from control unit, honoured only in IDLE
//   OPERAND1  in   DATA_W  multiplicand (register-file OUT1)
//   OPERAND2  in   DATA_W  multiplier   (register-file OUT2)
//   RESULT    out  DATA_W  low half of the unsigned product, held until next op
//   BUSY      out  1       pipeline stall request, high only while in RUN
//   DONE      out  1       one-cycle result-valid / register-file write strobe
//   OVERFLOW  out  1       upper half of the full product is non-zero
// ---------------------------------------------------------------------------
module mult_unit #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [DATA_W-1:0] OPERAND1,
    input  logic [DATA_W-1:0] OPERAND2,
    output logic [DATA_W-1:0] RESULT,
    output logic              BUSY,
    output logic              DONE,
    output logic              OVERFLOW
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    // Counter value while the final shift-add step is being performed.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [2*DATA_W-1:0]   r_mcand;
    logic [DATA_W-1:0]     r_mplier;
    logic [2*DATA_W-1:0]   r_acc;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_W-1:0]     r_result;
    logic                  r_overflow;
    logic                  r_busy;
    logic                  r_done;

    logic [2*DATA_W-1:0]   w_addend;
    logic [2*DATA_W-1:0]   w_acc_next;
    logic                  w_last;

    // Partial-product step: full 2*DATA_W wide so no carry is ever lost.
    always_comb begin
        w_addend   = {(2*DATA_W){1'b0}};
        if (r_mplier[0]) begin
            w_addend = r_mcand;
        end else begin
            w_addend = {(2*DATA_W){1'b0}};
        end
        w_acc_next = r_acc + w_addend;
        w_last     = (r_cnt == CNT_LAST);
    end

    // Next-state logic for the IDLE -> RUN -> DONE_ST -> IDLE sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand capture and one shift-add iteration per RUN cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_mcand  <= {(2*DATA_W){1'b0}};
            r_mplier <= {DATA_W{1'b0}};
            r_acc    <= {(2*DATA_W){1'b0}};
            r_cnt    <= CNT_ZERO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        r_mcand  <= {{DATA_W{1'b0}}, OPERAND1};
                        r_mplier <= OPERAND2;
                        r_acc    <= {(2*DATA_W){1'b0}};
                        r_cnt    <= CNT_ZERO;
                    end
                end
                ST_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_ONE;
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    // Registered status flags follow the next state; the result is loaded
    // from the final accumulator sum on the edge that enters DONE_ST and is
    // then held until the next completion.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= {DATA_W{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            r_busy <= (w_state_next == ST_RUN);
            r_done <= (w_state_next == ST_DONE);
            if ((r_state == ST_RUN) && w_last) begin
                r_result   <= w_acc_next[DATA_W-1:0];
                r_overflow <= |w_acc_next[2*DATA_W-1:DATA_W];
            end
        end
    end

    assign RESULT   = r_result;
    assign OVERFLOW = r_overflow;
    assign BUSY     = r_busy;
    assign DONE     = r_done;

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: a driver issues multiplies and pushes
// the expected product and capture cycle into a scoreboard; a monitor checks
// BUSY/DONE/RESULT/OVERFLOW every cycle against the scoreboard head.
module tb_mult_unit;
    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         START = 1'b0;
    logic [W-1:0] OPERAND1 = '0;
    logic [W-1:0] OPERAND2 = '0;
    logic [W-1:0] RESULT;
    logic         BUSY;
    logic         DONE;
    logic         OVERFLOW;

    mult_unit #(.DATA_W(W)) dut (
        .CLK(CLK), .RESET(RESET), .START(START),
        .OPERAND1(OPERAND1), .OPERAND2(OPERAND2),
        .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int           cap;
        logic [W-1:0] res;
        logic         ovf;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] last_res = '0;
    logic         last_ovf = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: plain unsigned multiplication of the captured operands.
    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   full;
        full  = int'(a) * int'(b);
        e.cap = cyc;
        e.res = full[W-1:0];
        e.ovf = (full >> W) != 0;
        sb.push_back(e);
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Monitor: the head entry says when the unit must be busy and when DONE fires.
    initial forever begin
        logic exp_busy;
        logic exp_done;
        @(negedge CLK);
        if (!RESET) begin
            exp_busy = 1'b0;
            exp_done = 1'b0;
            if (sb.size() > 0) begin
                exp_busy = (cyc >= sb[0].cap) && (cyc < sb[0].cap + W);
                exp_done = (cyc == sb[0].cap + W);
            end
            check("busy", 16'(BUSY), 16'(exp_busy));
            check("done", 16'(DONE), 16'(exp_done));
            if (exp_done) begin
                check("result", 16'(RESULT), 16'(sb[0].res));
                check("overflow", 16'(OVERFLOW), 16'(sb[0].ovf));
                last_res = sb[0].res;
                last_ovf = sb[0].ovf;
                void'(sb.pop_front());
            end else begin
                check("result_hold", 16'(RESULT), 16'(last_res));
                check("overflow_hold", 16'(OVERFLOW), 16'(last_ovf));
            end
        end
    end

    // Wait for the scoreboard to drain. mode 1: random operand churn and START
    // pulses while running; mode 2: operands forced to 1 with START held a while.
    task automatic drain(input int mode);
        int i;
        i = 0;
        while (sb.size() > 0 && i < 40) begin
            @(negedge CLK);
            #1;
            i++;
            if (sb.size() > 0) begin
                if (mode == 1) begin
                    OPERAND1 = W'($urandom);
                    OPERAND2 = W'($urandom);
                    START    = 1'($urandom);
                end else if (mode == 2) begin
                    OPERAND1 = 8'h01;
                    OPERAND2 = 8'h01;
                    START    = (i < 4);
                end
            end
        end
        START = 1'b0;
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int mode);
        @(negedge CLK);
        START    = 1'b1;
        OPERAND1 = a;
        OPERAND2 = b;
        @(posedge CLK);
        #1;
        push(a, b);
        START = 1'b0;
        drain(mode);
    endtask

    initial begin
        // Reset state; START while in reset must be ignored.
        #2;
        START = 1'b1;
        OPERAND1 = 8'h05;
        OPERAND2 = 8'h03;
        check("rst_result", 16'(RESULT), 16'h0000);
        check("rst_busy", 16'(BUSY), 16'h0000);
        check("rst_done", 16'(DONE), 16'h0000);
        check("rst_overflow", 16'(OVERFLOW), 16'h0000);
        repeat (2) @(posedge CLK);
        #1;
        check("rst_busy_start", 16'(BUSY), 16'h0000);
        START = 1'b0;
        @(posedge CLK);
        #2;
        RESET = 1'b0;

        do_op(8'h05, 8'h03, 0);
        do_op(8'h10, 8'h10, 0);
        do_op(8'hFF, 8'hFF, 0);
        do_op(8'h00, 8'hFF, 0);
        do_op(8'h0C, 8'h0A, 2);

        // Reset on the 4th RUN cycle of 0x09*0x09, then 0x07*0x06.
        @(negedge CLK);
        START = 1'b1;
        OPERAND1 = 8'h09;
        OPERAND2 = 8'h09;
        @(posedge CLK);
        #1;
        push(8'h09, 8'h09);
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        RESET = 1'b1;
        sb.delete();
        last_res = '0;
        last_ovf = 1'b0;
        #1;
        check("async_rst_result", 16'(RESULT), 16'h0000);
        check("async_rst_busy", 16'(BUSY), 16'h0000);
        check("async_rst_done", 16'(DONE), 16'h0000);
        check("async_rst_overflow", 16'(OVERFLOW), 16'h0000);
        repeat (2) @(posedge CLK);
        #2;
        RESET = 1'b0;
        do_op(8'h07, 8'h06, 0);

        // START held high: a capture every 10 cycles.
        @(negedge CLK);
        START = 1'b1;
        OPERAND1 = 8'h02;
        OPERAND2 = 8'h03;
        @(posedge CLK);
        #1;
        push(8'h02, 8'h03);
        for (int k = 0; k < 2; k++) begin
            repeat (10) @(posedge CLK);
            #1;
            push(8'h02, 8'h03);
        end
        START = 1'b0;
        drain(0);

        // Randomized operations with operand churn and spurious START in RUN.
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            do_op(W'($urandom), W'($urandom), 1);
        end
        repeat (3) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end
endmodule
